alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Single-issue integer ALU with an iterative multiply/divide unit.
// Simple ops complete in one cycle; MUL*/DIV*/REM* take XLEN+1 cycles.
module alu_muldiv #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ROB_W = 4,
  parameter int unsigned OP_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             rs_ready,
  input  logic [OP_W-1:0]  rs_op,
  input  logic [XLEN-1:0]  rs_val1,
  input  logic [XLEN-1:0]  rs_val2,
  input  logic [ROB_W-1:0] rs_id,
  output logic             alu_idle,
  output logic             alu_ready,
  output logic [XLEN-1:0]  alu_res,
  output logic [ROB_W-1:0] alu_id
);

  localparam int unsigned     ShW     = $clog2(XLEN);
  localparam int unsigned     CntW    = ShW + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);
  localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [OP_W-1:0] OpAdd    = OP_W'(0);
  localparam logic [OP_W-1:0] OpSub    = OP_W'(1);
  localparam logic [OP_W-1:0] OpAnd    = OP_W'(2);
  localparam logic [OP_W-1:0] OpOr     = OP_W'(3);
  localparam logic [OP_W-1:0] OpXor    = OP_W'(4);
  localparam logic [OP_W-1:0] OpShl    = OP_W'(5);
  localparam logic [OP_W-1:0] OpShr    = OP_W'(6);
  localparam logic [OP_W-1:0] OpShra   = OP_W'(7);
  localparam logic [OP_W-1:0] OpEq     = OP_W'(8);
  localparam logic [OP_W-1:0] OpNeq    = OP_W'(9);
  localparam logic [OP_W-1:0] OpLt     = OP_W'(10);
  localparam logic [OP_W-1:0] OpLtu    = OP_W'(11);
  localparam logic [OP_W-1:0] OpGe     = OP_W'(12);
  localparam logic [OP_W-1:0] OpGeu    = OP_W'(13);
  localparam logic [OP_W-1:0] OpMul    = OP_W'(16);
  localparam logic [OP_W-1:0] OpMulh   = OP_W'(17);
  localparam logic [OP_W-1:0] OpMulhsu = OP_W'(18);
  localparam logic [OP_W-1:0] OpMulhu  = OP_W'(19);
  localparam logic [OP_W-1:0] OpDiv    = OP_W'(20);
  localparam logic [OP_W-1:0] OpDivu   = OP_W'(21);
  localparam logic [OP_W-1:0] OpRem    = OP_W'(22);
  localparam logic [OP_W-1:0] OpRemu   = OP_W'(23);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e            r_state, w_state_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic              r_ready, w_ready_d;
  logic [XLEN-1:0]   r_res, w_res_d;
  logic [ROB_W-1:0]  r_res_id, w_res_id_d;

  // Operation context captured at acceptance
  logic [OP_W-1:0]   r_op;
  logic [ROB_W-1:0]  r_id;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_acc;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_opnd;

  logic              w_is_mul, w_is_div, w_signed1, w_signed2, w_sign1, w_sign2;
  logic              w_div_zero, w_div_ovf, w_go_mul, w_go_div, w_accept;
  logic [XLEN-1:0]   w_mag1, w_mag2, w_alu_res, w_mc_res;
  logic [ShW-1:0]    w_shamt;
  logic [XLEN:0]     w_mul_sum, w_div_shift, w_div_diff;
  logic [2*XLEN-1:0] w_mul_prod, w_prod_fix;
  logic [XLEN-1:0]   w_div_rem, w_div_quo, w_quo_fix, w_rem_fix;
  logic              w_div_ok;

  assign alu_idle  = (r_state == StIdle);
  assign alu_ready = r_ready;
  assign alu_res   = r_res;
  assign alu_id    = r_res_id;

  assign w_is_mul   = (rs_op == OpMul) || (rs_op == OpMulh) || (rs_op == OpMulhsu) ||
                      (rs_op == OpMulhu);
  assign w_is_div   = (rs_op == OpDiv) || (rs_op == OpDivu) || (rs_op == OpRem) ||
                      (rs_op == OpRemu);
  assign w_signed1  = (rs_op == OpMul) || (rs_op == OpMulh) || (rs_op == OpMulhsu) ||
                      (rs_op == OpDiv) || (rs_op == OpRem);
  assign w_signed2  = (rs_op == OpMul) || (rs_op == OpMulh) || (rs_op == OpDiv) ||
                      (rs_op == OpRem);
  assign w_sign1    = w_signed1 & rs_val1[XLEN-1];
  assign w_sign2    = w_signed2 & rs_val2[XLEN-1];
  assign w_mag1     = w_sign1 ? -rs_val1 : rs_val1;
  assign w_mag2     = w_sign2 ? -rs_val2 : rs_val2;
  assign w_div_zero = (rs_val2 == '0);
  assign w_div_ovf  = ((rs_op == OpDiv) || (rs_op == OpRem)) && (rs_val1 == MinNeg) &&
                      (rs_val2 == '1);
  assign w_go_mul   = w_is_mul;
  assign w_go_div   = w_is_div && !w_div_zero && !w_div_ovf;
  assign w_accept   = rs_ready && alu_idle && !flush;
  assign w_shamt    = rs_val2[ShW-1:0];

  // Single-cycle results, including the divide corner cases that bypass the iterator
  always_comb begin
    w_alu_res = '0;
    case (rs_op)
      OpAdd:           w_alu_res = rs_val1 + rs_val2;
      OpSub:           w_alu_res = rs_val1 - rs_val2;
      OpAnd:           w_alu_res = rs_val1 & rs_val2;
      OpOr:            w_alu_res = rs_val1 | rs_val2;
      OpXor:           w_alu_res = rs_val1 ^ rs_val2;
      OpShl:           w_alu_res = rs_val1 << w_shamt;
      OpShr:           w_alu_res = rs_val1 >> w_shamt;
      OpShra:          w_alu_res = $unsigned($signed(rs_val1) >>> w_shamt);
      OpEq:            w_alu_res = XLEN'(rs_val1 == rs_val2);
      OpNeq:           w_alu_res = XLEN'(rs_val1 != rs_val2);
      OpLt:            w_alu_res = XLEN'($signed(rs_val1) < $signed(rs_val2));
      OpLtu:           w_alu_res = XLEN'(rs_val1 < rs_val2);
      OpGe:            w_alu_res = XLEN'($signed(rs_val1) >= $signed(rs_val2));
      OpGeu:           w_alu_res = XLEN'(rs_val1 >= rs_val2);
      OpDiv, OpDivu:   w_alu_res = w_div_zero ? '1 : rs_val1;
      OpRem, OpRemu:   w_alu_res = w_div_zero ? rs_val1 : '0;
      default:         w_alu_res = '0;
    endcase
  end

  // One shift-add / restore-subtract step; r_acc is the high half / partial remainder
  assign w_mul_sum   = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_prod  = {w_mul_sum, r_lo[XLEN-1:1]};
  assign w_prod_fix  = r_neg_q ? -w_mul_prod : w_mul_prod;
  assign w_div_shift = {r_acc, r_lo[XLEN-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
  assign w_div_ok    = !w_div_diff[XLEN];
  assign w_div_rem   = w_div_ok ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
  assign w_div_quo   = {r_lo[XLEN-2:0], w_div_ok};
  assign w_quo_fix   = r_neg_q ? -w_div_quo : w_div_quo;
  assign w_rem_fix   = r_neg_r ? -w_div_rem : w_div_rem;

  always_comb begin
    w_mc_res = '0;
    if (r_state == StMul) begin
      w_mc_res = (r_op == OpMul) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
    end else if (r_state == StDiv) begin
      w_mc_res = ((r_op == OpDiv) || (r_op == OpDivu)) ? w_quo_fix : w_rem_fix;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_ready_d  = 1'b0;
    w_res_d    = r_res;
    w_res_id_d = r_res_id;
    if (flush) begin
      w_state_d = StIdle;
      w_cnt_d   = '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (rs_ready) begin
            if (w_go_mul) begin
              w_state_d = StMul;
              w_cnt_d   = '0;
            end else if (w_go_div) begin
              w_state_d = StDiv;
              w_cnt_d   = '0;
            end else begin
              w_ready_d  = 1'b1;
              w_res_d    = w_alu_res;
              w_res_id_d = rs_id;
            end
          end
        end
        StMul, StDiv: begin
          if (r_cnt == CntLast) begin
            w_state_d  = StIdle;
            w_cnt_d    = '0;
            w_ready_d  = 1'b1;
            w_res_d    = w_mc_res;
            w_res_id_d = r_id;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_ready  <= 1'b0;
      r_res    <= '0;
      r_res_id <= '0;
    end else if (rdy) begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_ready  <= w_ready_d;
      r_res    <= w_res_d;
      r_res_id <= w_res_id_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && w_accept) begin
      r_op    <= rs_op;
      r_id    <= rs_id;
      r_neg_q <= w_sign1 ^ w_sign2;
      r_neg_r <= w_sign1;
      r_acc   <= '0;
      r_lo    <= w_go_mul ? w_mag2 : w_mag1;
      r_opnd  <= w_go_mul ? w_mag1 : w_mag2;
    end else if (rdy && !flush && (r_state == StMul)) begin
      {r_acc, r_lo} <= w_mul_prod;
    end else if (rdy && !flush && (r_state == StDiv)) begin
      r_acc <= w_div_rem;
      r_lo  <= w_div_quo;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed corner cases plus randomized ops
// checked against an arithmetic reference model.
module tb_alu_muldiv;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, rs_ready;
  logic [4:0]  rs_op;
  logic [31:0] rs_val1, rs_val2;
  logic [3:0]  rs_id;
  logic        alu_idle, alu_ready;
  logic [31:0] alu_res;
  logic [3:0]  alu_id;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.XLEN(32), .ROB_W(4), .OP_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .flush    (flush),
    .rs_ready (rs_ready),
    .rs_op    (rs_op),
    .rs_val1  (rs_val1),
    .rs_val2  (rs_val2),
    .rs_id    (rs_id),
    .alu_idle (alu_idle),
    .alu_ready(alu_ready),
    .alu_res  (alu_res),
    .alu_id   (alu_id)
  );

  function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return a << b[4:0];
      5'd6:  return a >> b[4:0];
      5'd7:  return 32'($signed(a) >>> b[4:0]);
      5'd8:  return {31'b0, a == b};
      5'd9:  return {31'b0, a != b};
      5'd10: return {31'b0, sa < sb};
      5'd11: return {31'b0, ua < ub};
      5'd12: return {31'b0, sa >= sb};
      5'd13: return {31'b0, ua >= ub};
      5'd16: begin p = 64'(sa * sb); return p[31:0]; end
      5'd17: begin p = 64'(sa * sb); return p[63:32]; end
      5'd18: begin p = 64'(sa * ub); return p[63:32]; end
      5'd19: begin p = 64'(ua * ub); return p[63:32]; end
      5'd20: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return 32'(sa / sb);
      end
      5'd21: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      5'd22: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(sa % sb);
      end
      5'd23: return (b == 0) ? a : 32'(ua % ub);
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (op >= 5'd16 && op <= 5'd19) return XLEN + 1;
    if (op >= 5'd20 && op <= 5'd23) begin
      if (b == 0) return 1;
      if ((op == 5'd20 || op == 5'd22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 1;
    end
    return 1;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(5, 0))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(20, 0));
      default: return 32'($urandom);
    endcase
  endfunction

  // Presents one op and waits (bounded) for its result; lat = -1 on timeout.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] id, output logic [31:0] res, output logic [3:0] rid,
                       output int lat, output int idle_low);
    rs_op = op; rs_val1 = a; rs_val2 = b; rs_id = id; rs_ready = 1'b1;
    lat = -1; idle_low = 0; res = '0; rid = '0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      rs_ready = 1'b0;
      if (alu_ready) begin
        lat = c; res = alu_res; rid = alu_id;
        break;
      end
      if (!alu_idle) idle_low++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b0; flush = 1'b1; rs_ready = 1'b1;
    rs_op = 5'd0; rs_val1 = 32'd7; rs_val2 = 32'd9; rs_id = 4'd5;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (alu_ready !== 1'b0) begin tests_failed++;
      $display("FAIL reset_ready: got %b expected 0", alu_ready); end
    tests_run++; if (alu_res !== 32'h0) begin tests_failed++;
      $display("FAIL reset_res: got %h expected 0", alu_res); end
    tests_run++; if (alu_id !== 4'h0) begin tests_failed++;
      $display("FAIL reset_id: got %h expected 0", alu_id); end
    tests_run++; if (alu_idle !== 1'b1) begin tests_failed++;
      $display("FAIL reset_idle: got %b expected 1", alu_idle); end
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; rs_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [4:0]  d_op [7] = '{5'd0, 5'd17, 5'd18, 5'd20, 5'd22, 5'd21, 5'd20};
    logic [31:0] d_a  [7] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'd5, 32'h8000_0000};
    logic [31:0] d_b  [7] = '{32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd0,
                              32'hFFFF_FFFF};
    logic [31:0] d_exp[7] = '{32'h0, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    int          d_lat[7] = '{1, 33, 33, 33, 33, 1, 1};
    int          d_idl[7] = '{0, 32, 32, 32, 32, 0, 0};
    logic [31:0] res;
    logic [3:0]  rid;
    int lat, idle_low;
    for (int i = 0; i < 7; i++) begin
      issue(d_op[i], d_a[i], d_b[i], 4'(i + 3), res, rid, lat, idle_low);
      tests_run++; if (res !== d_exp[i]) begin tests_failed++;
        $display("FAIL directed_res[%0d]: got %h expected %h", i, res, d_exp[i]); end
      tests_run++; if (rid !== 4'(i + 3)) begin tests_failed++;
        $display("FAIL directed_id[%0d]: got %h expected %h", i, rid, 4'(i + 3)); end
      tests_run++; if (lat != d_lat[i]) begin tests_failed++;
        $display("FAIL directed_lat[%0d]: got %0d expected %0d", i, lat, d_lat[i]); end
      tests_run++; if (idle_low != d_idl[i]) begin tests_failed++;
        $display("FAIL directed_idle[%0d]: got %0d expected %0d", i, idle_low, d_idl[i]); end
      @(posedge clk); #1;
      tests_run++; if (alu_ready !== 1'b0) begin tests_failed++;
        $display("FAIL directed_pulse[%0d]: got %b expected 0", i, alu_ready); end
      tests_run++; if (alu_res !== d_exp[i]) begin tests_failed++;
        $display("FAIL directed_hold[%0d]: got %h expected %h", i, alu_res, d_exp[i]); end
    end
  endtask

  task automatic test_random();
    int unsigned ops [26] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13,
                              16, 17, 18, 19, 20, 21, 22, 23, 14, 15, 24, 31};
    logic [4:0]  op;
    logic [31:0] a, b, res, exp;
    logic [3:0]  id, rid;
    int lat, idle_low, elat;
    for (int i = 0; i < 80; i++) begin
      op = 5'(ops[$urandom_range(25, 0)]);
      a = rnd_val(); b = rnd_val(); id = 4'($urandom);
      exp = ref_res(op, a, b);
      elat = ref_lat(op, a, b);
      issue(op, a, b, id, res, rid, lat, idle_low);
      tests_run++; if (res !== exp || rid !== id) begin tests_failed++;
        $display("FAIL random_res op=%0d a=%h b=%h: got %h/%h expected %h/%h",
                 op, a, b, res, rid, exp, id); end
      tests_run++; if (lat != elat || idle_low != elat - 1) begin tests_failed++;
        $display("FAIL random_lat op=%0d: got lat %0d idle %0d expected %0d/%0d",
                 op, lat, idle_low, elat, elat - 1); end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  op;
    logic [31:0] a, b, exp_mul;
    int lat = -1;
    rs_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = 5'($urandom_range(13, 0)); a = rnd_val(); b = rnd_val();
      rs_op = op; rs_val1 = a; rs_val2 = b; rs_id = 4'(i);
      @(posedge clk); #1;
      tests_run++;
      if (alu_ready !== 1'b1 || alu_res !== ref_res(op, a, b) || alu_id !== 4'(i)) begin
        tests_failed++;
        $display("FAIL b2b[%0d] op=%0d: got %b/%h/%h expected 1/%h/%h", i, op, alu_ready,
                 alu_res, alu_id, ref_res(op, a, b), 4'(i));
      end
    end
    // Busy unit must ignore a request held on the RS until the multiply completes
    a = rnd_val(); b = rnd_val(); exp_mul = ref_res(5'd16, a, b);
    rs_op = 5'd16; rs_val1 = a; rs_val2 = b; rs_id = 4'd11;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin rs_op = 5'd0; rs_val1 = 32'd1000; rs_val2 = 32'd234; rs_id = 4'd12; end
      if (alu_ready) begin lat = c; break; end
    end
    tests_run++;
    if (lat != XLEN + 1 || alu_res !== exp_mul || alu_id !== 4'd11) begin tests_failed++;
      $display("FAIL busy_mul: got lat %0d %h/%h expected %0d %h/b", lat, alu_res, alu_id,
               XLEN + 1, exp_mul); end
    @(posedge clk); #1;
    rs_ready = 1'b0;
    tests_run++;
    if (alu_ready !== 1'b1 || alu_res !== 32'd1234 || alu_id !== 4'd12) begin tests_failed++;
      $display("FAIL busy_next: got %b/%h/%h expected 1/000004d2/c", alu_ready, alu_res,
               alu_id); end
    @(posedge clk); #1;
  endtask

  task automatic test_rdy_stall();
    logic [31:0] held_res;
    logic [3:0]  held_id;
    int lat = -1;
    held_res = '0; held_id = '0;
    rs_op = 5'd16; rs_val1 = 32'd3; rs_val2 = 32'd5; rs_id = 4'd4; rs_ready = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk); #1;
      rs_ready = 1'b0;
      if (c >= 11 && c <= 14) begin
        tests_run++;
        if (alu_ready !== 1'b0 || alu_idle !== 1'b0 || alu_res !== held_res ||
            alu_id !== held_id) begin tests_failed++;
          $display("FAIL stall_freeze c=%0d: got %b/%b/%h/%h expected 0/0/%h/%h", c,
                   alu_ready, alu_idle, alu_res, alu_id, held_res, held_id); end
      end
      if (c == 10) begin held_res = alu_res; held_id = alu_id; rdy = 1'b0; end
      if (c == 14) rdy = 1'b1;
      if (alu_ready) begin lat = c; break; end
    end
    tests_run++;
    if (lat != XLEN + 5 || alu_res !== 32'd15 || alu_id !== 4'd4) begin tests_failed++;
      $display("FAIL stall_result: got lat %0d %h/%h expected %0d 0000000f/4", lat, alu_res,
               alu_id, XLEN + 5); end
    // A result pulse is held, not dropped, while rdy is low
    rdy = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (alu_ready !== 1'b1 || alu_res !== 32'd15) begin tests_failed++;
      $display("FAIL stall_pulse_hold: got %b/%h expected 1/0000000f", alu_ready, alu_res); end
    rdy = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (alu_ready !== 1'b0) begin tests_failed++;
      $display("FAIL stall_pulse_end: got %b expected 0", alu_ready); end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    logic [3:0]  rid;
    int lat, idle_low;
    int seen = 0;
    rs_op = 5'd21; rs_val1 = 32'd100; rs_val2 = 32'd7; rs_id = 4'd9; rs_ready = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      rs_ready = 1'b0;
      if (c == 11) begin
        flush = 1'b0;
        tests_run++; if (alu_idle !== 1'b1 || alu_ready !== 1'b0) begin tests_failed++;
          $display("FAIL flush_idle: got idle %b ready %b expected 1/0", alu_idle,
                   alu_ready); end
      end
      if (c == 10) flush = 1'b1;
      if (alu_ready) seen++;
    end
    tests_run++; if (seen != 0) begin tests_failed++;
      $display("FAIL flush_no_result: got %0d results expected 0", seen); end
    issue(5'd0, 32'd2, 32'd3, 4'd5, res, rid, lat, idle_low);
    tests_run++; if (res !== 32'd5 || rid !== 4'd5 || lat != 1) begin tests_failed++;
      $display("FAIL flush_add: got %h/%h lat %0d expected 00000005/5 lat 1", res, rid,
               lat); end
  endtask

  task automatic test_reset_mid_op();
    int seen = 0;
    rs_op = 5'd20; rs_val1 = 32'hFFFF_FFF9; rs_val2 = 32'd2; rs_id = 4'd6; rs_ready = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      rs_ready = 1'b0;
      if (c == 6) begin
        rst = 1'b0;
        tests_run++;
        if (alu_ready !== 1'b0 || alu_res !== 32'h0 || alu_id !== 4'h0 || alu_idle !== 1'b1)
        begin tests_failed++;
          $display("FAIL rst_mid: got %b/%h/%h idle %b expected 0/0/0 idle 1", alu_ready,
                   alu_res, alu_id, alu_idle); end
      end
      if (c == 5) rst = 1'b1;
      if (alu_ready) seen++;
    end
    tests_run++; if (seen != 0) begin tests_failed++;
      $display("FAIL rst_stale: got %0d results expected 0", seen); end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; rs_ready = 1'b0;
    rs_op = '0; rs_val1 = '0; rs_val2 = '0; rs_id = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_rdy_stall();
    test_flush();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
